// File: rtl/voice_cmd_dispatch.sv
// Takes the decision stage's command pulses, validates them, suppresses fast repeats
// and queues accepted codes for the controller over valid/ready.
module voice_cmd_dispatch #(
  parameter int DEPTH       = 4,
  parameter int REPEAT_GAP  = 25000000,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       training_enable,
  input  logic [3:0] command,
  output logic [3:0] cmd_out,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [3:0] last_cmd,
  output logic [7:0] drop_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (REPEAT_GAP > 1) ? $clog2(REPEAT_GAP) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(REPEAT_GAP - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [GW-1:0] gap_q;
  logic [HW-1:0] hold_q;
  logic [3:0]    last_acc_q, last_cmd_q;
  logic [7:0]    drop_q;

  logic evt, valid_code, suppressed, full, pop, push, drop_inc;

  assign cmd_valid  = (cnt_q != '0);
  assign cmd_out    = mem_q[rd_ptr_q];
  assign last_cmd   = last_cmd_q;
  assign drop_count = drop_q;

  always_comb begin
    evt        = (command != 4'd0) && !training_enable;
    valid_code = (command >= 4'd4) && (command <= 4'd11);
    suppressed = (command == last_acc_q) && (gap_q != '0);
    full       = (cnt_q == FULL_CNT);
    pop        = cmd_valid && cmd_ready;
    push       = evt && valid_code && !suppressed && (!full || pop);
    // Suppressed repeats vanish silently; only invalid codes and overflow are counted.
    drop_inc   = evt && (!valid_code || (!suppressed && full && !pop));
    cnt_d      = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      hold_q     <= '0;
      last_acc_q <= 4'd0;
      last_cmd_q <= 4'd0;
      drop_q     <= 8'd0;
    end else begin
      if (training_enable) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= command;
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        cnt_q <= cnt_d;
      end

      if (push) begin
        last_acc_q <= command;
        gap_q      <= GAP_LOAD;
      end else if (gap_q != '0) begin
        gap_q <= gap_q - GW'(1);
      end

      // Display word clears one cycle after the hold counter has run down.
      if (push) begin
        last_cmd_q <= command;
        hold_q     <= HOLD_LOAD;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - HW'(1);
      end else begin
        last_cmd_q <= 4'd0;
      end

      if (drop_inc && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_voice_cmd_dispatch.sv
// Directed scenarios plus random traffic, all compared cycle by cycle against a queue-based model.
module tb_voice_cmd_dispatch;
  localparam int DEPTH = 4, GAP = 8, HOLD = 16;

  logic       clock = 1'b0;
  logic       reset, training_enable, cmd_ready, cmd_valid;
  logic [3:0] command, cmd_out, last_cmd;
  logic [7:0] drop_count;

  int n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  voice_cmd_dispatch #(.DEPTH(DEPTH), .REPEAT_GAP(GAP), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset(reset), .training_enable(training_enable),
    .command(command), .cmd_out(cmd_out), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .last_cmd(last_cmd), .drop_count(drop_count)
  );

  // Model: queue of accepted codes, cycle stamp of the last accept, drop tally.
  logic [3:0] mq[$];
  logic [3:0] m_code;
  bit         m_has;
  int         m_acc_cyc, m_drop, cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    int el;
    el = cyc - m_acc_cyc;
    chk("valid", cmd_valid, (mq.size() != 0));
    if (mq.size() != 0) chk("head", cmd_out, mq[0]);
    chk("last", last_cmd, (m_has && el < HOLD) ? m_code : 4'd0);
    chk("drop", drop_count, m_drop);
  endtask

  task automatic step(input logic [3:0] c, input bit rdy, input bit trn);
    bit pop, do_push;
    command = c; cmd_ready = rdy; training_enable = trn; reset = 1'b0;
    pop = (mq.size() != 0) && rdy;
    do_push = 1'b0;
    if (!trn && c != 0) begin
      if (c < 4 || c > 11) begin
        if (m_drop < 255) m_drop++;
      end else if (m_has && c == m_code && (cyc - m_acc_cyc) < GAP) begin
      end else if (mq.size() == DEPTH && !pop) begin
        if (m_drop < 255) m_drop++;
      end else do_push = 1'b1;
    end
    if (trn) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(c);
    end
    if (do_push) begin m_code = c; m_has = 1'b1; m_acc_cyc = cyc; end
    @(posedge clock); @(negedge clock);
    check_outputs();
    cyc++;
  endtask

  task automatic do_reset(input logic [3:0] c);
    reset = 1'b1; command = c; cmd_ready = 1'b1; training_enable = 1'b0;
    @(posedge clock); @(negedge clock);
    mq.delete(); m_has = 1'b0; m_code = 4'd0; m_drop = 0; m_acc_cyc = 0;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_out", cmd_out, 0);
    chk("rst_last", last_cmd, 0);
    chk("rst_drop", drop_count, 0);
    reset = 1'b0; command = 4'd0;
    cyc++;
  endtask

  initial begin
    logic [3:0] exp_seq [3];
    reset = 1'b1; command = 4'd0; cmd_ready = 1'b0; training_enable = 1'b0;
    cyc = 0; m_has = 1'b0; m_code = 4'd0; m_drop = 0; m_acc_cyc = 0;
    @(negedge clock);
    do_reset(4'd0);

    // Basic handshake
    step(4'b0101, 1, 0);
    chk("hs_valid", cmd_valid, 1);
    chk("hs_out", cmd_out, 4'b0101);
    step(4'd0, 1, 0);
    chk("hs_empty", cmd_valid, 0);
    chk("hs_last", last_cmd, 4'b0101);

    // Repeat suppression: 1010 @0, 1010 @3, 1011 @4, 1010 @12
    step(4'b1010, 1, 0);
    step(4'd0, 1, 0); step(4'd0, 1, 0);
    step(4'b1010, 1, 0);
    chk("rep_sup", cmd_valid, 0);
    step(4'b1011, 1, 0);
    chk("rep_b", cmd_out, 4'b1011);
    for (int i = 5; i < 12; i++) step(4'd0, 1, 0);
    step(4'b1010, 1, 0);
    chk("rep_a2", cmd_out, 4'b1010);
    chk("rep_drop", drop_count, 0);
    step(4'd0, 1, 0);

    // Overflow, then push+pop while full
    for (int i = 4; i <= 8; i++) step(4'(i), 0, 0);
    chk("ovf_drop", drop_count, 1);
    chk("ovf_head", cmd_out, 4'b0100);
    step(4'b1001, 1, 0);
    chk("ovf_pp_drop", drop_count, 1);
    chk("ovf_pp_head", cmd_out, 4'b0101);
    exp_seq[0] = 4'b0110; exp_seq[1] = 4'b0111; exp_seq[2] = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      step(4'd0, 1, 0);
      chk("ovf_order", cmd_out, exp_seq[i]);
    end
    step(4'd0, 1, 0);
    chk("ovf_empty", cmd_valid, 0);

    // Invalid codes saturate the drop counter
    for (int i = 0; i < 300; i++) step(4'b1111, 1, 0);
    chk("inv_sat", drop_count, 8'hFF);
    chk("inv_nopush", cmd_valid, 0);

    // Training flush
    step(4'b0100, 0, 0); step(4'b0101, 0, 0); step(4'b0110, 0, 0);
    step(4'b0111, 0, 1);
    chk("trn_flush", cmd_valid, 0);
    step(4'd0, 0, 1);
    step(4'd0, 0, 0);
    chk("trn_empty", cmd_valid, 0);
    chk("trn_drop", drop_count, 8'hFF);

    // Hold expiry
    step(4'b1011, 0, 0);
    for (int i = 1; i < HOLD; i++) begin
      step(4'd0, 0, 0);
      chk("hold_on", last_cmd, 4'b1011);
    end
    step(4'd0, 0, 0);
    chk("hold_off", last_cmd, 0);

    // Reset mid-queue, with a pulse present in the same cycle
    step(4'b0100, 0, 0); step(4'b0101, 0, 0);
    do_reset(4'b0110);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r, v;
      logic [3:0] c;
      r = $urandom_range(0, 99);
      if (r < 50) c = 4'd0;
      else if (r < 75) c = 4'($urandom_range(4, 6));
      else if (r < 92) c = 4'($urandom_range(4, 11));
      else begin
        v = $urandom_range(0, 6);
        c = (v < 3) ? 4'(v + 1) : 4'(v + 9);
      end
      if ($urandom_range(0, 499) == 0) do_reset(c);
      else step(c, $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
